game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 161 ++++++++++++++++
 tb/tb_game_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: button conditioning (synchroniser + debouncer) and the
// IDLE/RUN/OVER/RESTART game state machine. Every output is a flop.
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int FLAP_HOLD       = 5_000_000,
    parameter int OVER_LOCK       = 12_500_000,
    parameter int RESTART_LEN     = 4
) (
    input  logic       clk_25MHz,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_flap,
    input  logic       lose,
    output logic       game_start,
    output logic       flap,
    output logic       game_reset,
    output logic [1:0] state,
    output logic [7:0] games_played
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FH_W = $clog2(FLAP_HOLD + 1);
    localparam int OL_W = $clog2(OVER_LOCK + 1);
    localparam int RL_W = $clog2(RESTART_LEN + 1);

    localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FH_W-1:0] HOLD_INIT    = FH_W'(FLAP_HOLD - 1);
    localparam logic [OL_W-1:0] LOCK_INIT    = OL_W'(OVER_LOCK);
    localparam logic [RL_W-1:0] RESTART_INIT = RL_W'(RESTART_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_OVER    = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    // Bit 0 carries the start button, bit 1 the flap button.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_level;
    logic [DB_W-1:0] r_dbCnt [2];
    logic [1:0]      w_press;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            for (int b = 0; b < 2; b++) r_dbCnt[b] <= '0;
        end else begin
            r_sync1 <= {btn_flap, btn_start};
            r_sync2 <= r_sync1;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_level[b]) begin
                    r_dbCnt[b] <= '0;
                end else if (r_dbCnt[b] == DB_LAST) begin
                    r_level[b] <= r_sync2[b];
                    r_dbCnt[b] <= '0;
                end else begin
                    r_dbCnt[b] <= r_dbCnt[b] + 1'b1;
                end
            end
        end
    end

    // The press event fires on the same edge the level flips to 1, so the FSM reacts without an extra cycle.
    always_comb begin
        w_press = '0;
        for (int b = 0; b < 2; b++)
            w_press[b] = (r_sync2[b] != r_level[b]) && (r_dbCnt[b] == DB_LAST) && r_sync2[b];
    end

    logic w_startEvt;
    logic w_flapEvt;
    assign w_startEvt = w_press[0];
    assign w_flapEvt  = w_press[1];

    state_t          r_state;
    state_t          w_nextState;
    logic            r_gameStart, w_gameStartNext;
    logic            r_gameReset, w_gameResetNext;
    logic            r_flap, w_flapNext;
    logic [FH_W-1:0] r_holdCnt, w_holdNext;
    logic [OL_W-1:0] r_lockCnt, w_lockNext;
    logic [RL_W-1:0] r_restartCnt, w_restartNext;
    logic [7:0]      r_played, w_playedNext;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_gameStart  <= 1'b0;
            r_gameReset  <= 1'b0;
            r_flap       <= 1'b0;
            r_holdCnt    <= '0;
            r_lockCnt    <= '0;
            r_restartCnt <= '0;
            r_played     <= '0;
        end else begin
            r_state      <= w_nextState;
            r_gameStart  <= w_gameStartNext;
            r_gameReset  <= w_gameResetNext;
            r_flap       <= w_flapNext;
            r_holdCnt    <= w_holdNext;
            r_lockCnt    <= w_lockNext;
            r_restartCnt <= w_restartNext;
            r_played     <= w_playedNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_startEvt) w_nextState = S_RUN;
            S_RUN:     if (lose) w_nextState = S_OVER;
            S_OVER:    if (w_startEvt && r_lockCnt == '0) w_nextState = S_RESTART;
            S_RESTART: if (r_restartCnt == '0) w_nextState = S_RUN;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they land in flops on the same edge as the state.
    always_comb begin
        w_gameStartNext = (w_nextState == S_RUN);
        w_gameResetNext = (w_nextState == S_RESTART);
        w_flapNext      = 1'b0;
        w_holdNext      = '0;
        w_lockNext      = r_lockCnt;
        w_restartNext   = r_restartCnt;
        w_playedNext    = r_played;

        if (r_state == S_RUN && w_nextState == S_RUN) begin
            if (w_flapEvt) begin
                w_flapNext = 1'b1;
                w_holdNext = HOLD_INIT;
            end else if (r_flap && r_holdCnt != '0) begin
                w_flapNext = 1'b1;
                w_holdNext = r_holdCnt - 1'b1;
            end
        end

        if (w_nextState == S_OVER && r_state != S_OVER)
            w_lockNext = LOCK_INIT;
        else if (r_state == S_OVER && r_lockCnt != '0)
            w_lockNext = r_lockCnt - 1'b1;

        if (w_nextState == S_RESTART && r_state != S_RESTART)
            w_restartNext = RESTART_INIT;
        else if (r_state == S_RESTART && r_restartCnt != '0)
            w_restartNext = r_restartCnt - 1'b1;

        if (w_nextState == S_RUN && r_state != S_RUN && r_played != 8'hFF)
            w_playedNext = r_played + 8'd1;
    end

    assign state        = r_state;
    assign game_start   = r_gameStart;
    assign game_reset   = r_gameReset;
    assign flap         = r_flap;
    assign games_played = r_played;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random stimulus; a behavioural game model feeds a
// scoreboard of expected output changes that a negedge monitor checks.
module tb_game_ctrl;
    localparam int DB  = 4;
    localparam int FH  = 10;
    localparam int OL  = 20;
    localparam int RL  = 4;

    logic       clk_25MHz = 1'b0;
    logic       reset_n;
    logic       btn_start;
    logic       btn_flap;
    logic       lose;
    logic       game_start;
    logic       flap;
    logic       game_reset;
    logic [1:0] state;
    logic [7:0] games_played;

    game_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .FLAP_HOLD(FH),
        .OVER_LOCK(OL),
        .RESTART_LEN(RL)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .reset_n(reset_n),
        .btn_start(btn_start),
        .btn_flap(btn_flap),
        .lose(lose),
        .game_start(game_start),
        .flap(flap),
        .game_reset(game_reset),
        .state(state),
        .games_played(games_played)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    typedef struct {
        int          cyc;
        logic [12:0] snap;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    int          cycle = 0;
    int          flapRun = 0;
    int          lastFlapRun = 0;

    // Model state: raw button history, debounced level and mismatch run per button.
    int mSync1[2], mSync2[2], mLevel[2], mRun[2];
    int mState = 0, mFlapLeft = 0, mLockLeft = 0, mRestartLeft = 0, mPlayed = 0;
    logic [12:0] lastExp = '0;
    logic [12:0] lastDut = '0;

    function automatic logic [12:0] dutSnap();
        return {state, game_start, flap, game_reset, games_played};
    endfunction

    function automatic logic [12:0] mdlSnap();
        logic [1:0] st;
        logic [7:0] gp;
        st = 2'(mState);
        gp = 8'(mPlayed);
        return {st, mState == 1, mFlapLeft > 0, mState == 3, gp};
    endfunction

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            mSync1[b] = 0; mSync2[b] = 0; mLevel[b] = 0; mRun[b] = 0;
        end
        mState = 0; mFlapLeft = 0; mLockLeft = 0; mRestartLeft = 0; mPlayed = 0;
    endtask

    task automatic modelStep();
        int raw[2];
        int evt[2];
        raw[0] = int'(btn_start);
        raw[1] = int'(btn_flap);
        cycle++;
        for (int b = 0; b < 2; b++) begin
            evt[b] = 0;
            if (mSync2[b] != mLevel[b]) begin
                mRun[b]++;
                if (mRun[b] == DB) begin
                    mLevel[b] = mSync2[b];
                    mRun[b]   = 0;
                    evt[b]    = mLevel[b];
                end
            end else begin
                mRun[b] = 0;
            end
            mSync2[b] = mSync1[b];
            mSync1[b] = raw[b];
        end
        case (mState)
            0: if (evt[0] == 1) begin
                mState = 1;
                mPlayed = (mPlayed < 255) ? mPlayed + 1 : 255;
            end
            1: if (lose) begin
                mState = 2; mFlapLeft = 0; mLockLeft = OL;
            end else if (evt[1] == 1) begin
                mFlapLeft = FH;
            end else if (mFlapLeft > 0) begin
                mFlapLeft--;
            end
            2: if (mLockLeft > 0) mLockLeft--;
               else if (evt[0] == 1) begin mState = 3; mRestartLeft = RL; end
            default: begin
                mRestartLeft--;
                if (mRestartLeft == 0) begin
                    mState = 1;
                    mPlayed = (mPlayed < 255) ? mPlayed + 1 : 255;
                end
            end
        endcase
    endtask

    initial begin
        logic [12:0] snap;
        forever begin
            @(posedge clk_25MHz or negedge reset_n);
            if (!reset_n) modelReset();
            else modelStep();
            snap = mdlSnap();
            if (snap !== lastExp) begin
                sbQ.push_back('{cycle, snap});
                lastExp = snap;
            end
        end
    end

    // Monitor: any change on the outputs must match the next expected change, in the same cycle.
    initial begin
        logic [12:0] cur;
        sbEntry_t    e;
        forever begin
            @(negedge clk_25MHz);
            cur = dutSnap();
            if (cur !== lastDut) begin
                nCompared++;
                if (sbQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpected_change cycle %0d: got %h, none expected", cycle, cur);
                end else begin
                    e = sbQ.pop_front();
                    if (e.snap !== cur || e.cyc != cycle) begin
                        nMismatched++;
                        $display("[TB] FAIL output_change: got %h at cycle %0d, expected %h at cycle %0d",
                                 cur, cycle, e.snap, e.cyc);
                    end
                end
                lastDut = cur;
            end
            if (flap === 1'b1) flapRun++;
            else begin
                if (flapRun > 0) lastFlapRun = flapRun;
                flapRun = 0;
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic f, input logic l, input int cycles);
        btn_start = s;
        btn_flap  = f;
        lose      = l;
        repeat (cycles) @(posedge clk_25MHz);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        logic rs, rf;
        btn_start = 1'b0; btn_flap = 1'b0; lose = 1'b0; reset_n = 1'b1;
        #1 reset_n = 1'b0;
        applyStimulus(0, 0, 0, 3);
        checkOutput("reset_outputs", 32'(dutSnap()), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 1);
            applyStimulus(0, 0, 0, 2);
        end
        checkOutput("glitch_no_start", 32'(state), 32'd0);
        applyStimulus(1, 0, 0, 7);
        checkOutput("start_state", 32'(state), 32'd1);
        checkOutput("start_played", 32'(games_played), 32'd1);
        checkOutput("start_game_start", 32'(game_start), 32'd1);

        applyStimulus(0, 0, 0, 8);
        applyStimulus(0, 1, 0, 6);
        checkOutput("flap_rise", 32'(flap), 32'd1);
        applyStimulus(0, 0, 0, 20);
        checkOutput("flap_single_len", 32'(lastFlapRun), 32'd10);

        applyStimulus(0, 1, 0, 6);
        applyStimulus(0, 0, 0, 4);
        applyStimulus(0, 1, 0, 6);
        applyStimulus(0, 0, 0, 30);
        checkOutput("flap_retrigger_len", 32'(lastFlapRun), 32'd20);

        applyStimulus(0, 1, 0, 5);
        applyStimulus(0, 1, 1, 1);
        checkOutput("lose_flap_state", 32'(state), 32'd2);
        checkOutput("lose_flap_flap", 32'(flap), 32'd0);
        checkOutput("lose_flap_game_start", 32'(game_start), 32'd0);

        applyStimulus(0, 0, 0, 4);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 8);
        checkOutput("over_lock_ignore", 32'(state), 32'd2);
        applyStimulus(1, 0, 0, 6);
        checkOutput("restart_state", 32'(state), 32'd3);
        checkOutput("restart_game_reset", 32'(game_reset), 32'd1);
        checkOutput("restart_game_start", 32'(game_start), 32'd0);
        applyStimulus(1, 0, 0, 3);
        checkOutput("restart_last_cycle", 32'(state), 32'd3);
        applyStimulus(1, 0, 0, 1);
        checkOutput("restart_done_state", 32'(state), 32'd1);
        checkOutput("restart_done_played", 32'(games_played), 32'd2);
        checkOutput("restart_done_reset", 32'(game_reset), 32'd0);

        applyStimulus(0, 0, 0, 8);
        applyStimulus(0, 1, 0, 8);
        checkOutput("flap_before_reset", 32'(flap), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_flap", 32'(dutSnap()), 32'd0);
        applyStimulus(0, 0, 0, 2);
        reset_n = 1'b1;

        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 4);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 22);
        applyStimulus(1, 0, 0, 8);
        checkOutput("restart_before_reset", 32'(state), 32'd3);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_restart", 32'(dutSnap()), 32'd0);
        applyStimulus(1, 0, 0, 3);
        reset_n = 1'b1;
        applyStimulus(1, 0, 0, 5);
        checkOutput("held_through_reset_wait", 32'(state), 32'd0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("held_through_reset_run", 32'(state), 32'd1);
        checkOutput("held_through_reset_played", 32'(games_played), 32'd1);

        applyStimulus(0, 0, 0, 8);
        for (int g = 0; g < 256; g++) begin
            applyStimulus(0, 0, 1, 1);
            applyStimulus(0, 0, 0, 22);
            applyStimulus(1, 0, 0, 8);
            applyStimulus(0, 0, 0, 8);
        end
        checkOutput("saturate_played", 32'(games_played), 32'd255);
        checkOutput("saturate_state", 32'(state), 32'd1);

        applyStimulus(0, 0, 0, 60);
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 2);
        reset_n = 1'b1;
        rs = 1'b0;
        rf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            if ($urandom_range(0, 4) == 0) rf = ~rf;
            applyStimulus(rs, rf, ($urandom_range(0, 39) == 0), 1);
        end
        applyStimulus(0, 0, 0, 40);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
